// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

   typedef enum logic [2:0] {
      StCntLo,
      StCntHi,
      StLoad,
      StCheck,
      StDone,
      StErr
   } boot_state_e;

   localparam int unsigned HdrLen       = 2;
   localparam int unsigned BytesPerWord = 4;

   // Clock cycles per UART bit, rounded to nearest.
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// UART input plus instruction-memory write port and status of the boot loader.
interface boot_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              rx;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  rx,
      output imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err
   );

   modport slave (
      output rx,
      input  imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, err
   );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-start glitch rejection, stop-bit check.
module uart_rx_byte
   import boot_pkg::*;
#(
   parameter int unsigned Div = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o,
   output logic       start_o
);

   localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   rx_state_e       state_q;
   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shreg_q;
   logic [7:0]      byte_q;
   logic            valid_q, ferr_q, start_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= RxIdle;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         start_q   <= 1'b0;
         case (state_q)
            RxIdle: begin
               if (rx_prev_q && !rx_sync_q) begin
                  cnt_q   <= '0;
                  state_q <= RxStart;
               end
            end
            RxStart: begin
               // Line back high at mid start bit means a glitch; drop it silently.
               if (cnt_q == CntW'(Div / 2 - 1)) begin
                  cnt_q <= '0;
                  if (rx_sync_q) begin
                     state_q <= RxIdle;
                  end else begin
                     state_q   <= RxData;
                     bit_idx_q <= '0;
                     start_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            RxData: begin
               if (cnt_q == CntW'(Div - 1)) begin
                  cnt_q   <= '0;
                  shreg_q <= {rx_sync_q, shreg_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     state_q <= RxStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            RxStop: begin
               if (cnt_q == CntW'(Div - 1)) begin
                  cnt_q   <= '0;
                  state_q <= RxIdle;
                  if (rx_sync_q) begin
                     valid_q <= 1'b1;
                     byte_q  <= shreg_q;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= RxIdle;
         endcase
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign frame_err_o  = ferr_q;
   assign start_o      = start_q;

endmodule

// File: rtl/boot_loader.sv
// UART program loader: writes a little-endian word image into imem, then releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200,
   parameter int unsigned ADDR_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.master bus
);

   localparam int unsigned Div   = calc_div(CLK_HZ, BAUD);
   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_ferr, rx_start;

   boot_state_e       state_q;
   logic [7:0]        cnt_lo_q;
   logic [15:0]       n_q, word_q;
   logic [1:0]        idx_q;
   logic [23:0]       acc_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              core_rst_n_q, busy_q, done_q, err_q;
   logic [15:0]       cnt_n;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        xor_q;
`endif

   uart_rx_byte #(
      .Div (Div)
   ) u_rx (
      .clk_i        (clk),
      .rst_ni       (rst),
      .rx_i         (bus.rx),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_ferr),
      .start_o      (rx_start)
   );

   assign cnt_n = {rx_byte, cnt_lo_q};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StCntLo;
         cnt_lo_q     <= '0;
         n_q          <= '0;
         word_q       <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         xor_q        <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         if (rx_ferr && state_q != StDone && state_q != StErr) begin
            state_q <= StErr;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               StCntLo: begin
                  if (rx_start) busy_q <= 1'b1;
                  if (rx_valid) begin
                     cnt_lo_q <= rx_byte;
                     state_q  <= StCntHi;
                  end
               end
               StCntHi: begin
                  if (rx_valid) begin
                     n_q    <= cnt_n;
                     idx_q  <= '0;
                     word_q <= '0;
                     if (32'(cnt_n) > Depth) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                     end else if (cnt_n == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_q <= StCheck;
`else
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                     end else begin
                        state_q <= StLoad;
                     end
                  end
               end
               StLoad: begin
                  // Address advances in the cycle after the write strobe.
                  if (imem_we_q) begin
                     imem_addr_q <= imem_addr_q + ADDR_W'(1);
                     word_q      <= word_q + 16'd1;
                     if (word_q == n_q - 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
                        state_q <= StCheck;
`else
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                     end
                  end else if (rx_valid) begin
`ifdef BOOT_CHECKSUM_EN
                     xor_q <= xor_q ^ rx_byte;
`endif
                     case (idx_q)
                        2'd0: acc_q[7:0]   <= rx_byte;
                        2'd1: acc_q[15:8]  <= rx_byte;
                        2'd2: acc_q[23:16] <= rx_byte;
                        default: begin
                           imem_we_q    <= 1'b1;
                           imem_wdata_q <= {rx_byte, acc_q};
                        end
                     endcase
                     idx_q <= idx_q + 2'd1;
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               StCheck: begin
                  if (rx_valid) begin
                     busy_q <= 1'b0;
                     if (rx_byte == xor_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                     end
                  end
               end
`endif
               StDone: core_rst_n_q <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.core_rst_n = core_rst_n_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader sitting upstream of the FETCH stage. Receives a program image over a UART line, assembles little-endian 32-bit words and writes them into the instruction memory through a dedicated write port. Holds the pipeline (FETCH through WR) in reset until the image is fully and correctly loaded, then releases it so execution starts at word address 0.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate
- ADDR_W, 10, instruction-memory word-address width (depth = 2**ADDR_W words)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- rx  in  1  UART receive line, idle high, 8N1, asynchronous to clk
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of current write
- imem_wdata  out  32  word to write
- core_rst_n  out  1  active-low reset to the pipeline; 0 while loading
- busy  out  1  image reception in progress
- done  out  1  image accepted, core released
- err  out  1  load failed; core stays in reset

## Operation
- Host frame: count_lo, count_hi (16-bit word count N), then 4·N data bytes, each word least-significant byte first; optional checksum byte (see Configuration).
- rx passes through a 2-flop synchronizer before any use.
- Byte receiver: DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit. Falling edge on synced rx starts a frame; at DIV/2 the line is rechecked: high → glitch, frame discarded silently. Then 8 data bits sampled every DIV cycles (LSB first), then stop bit. Stop bit 0 → framing error.
- Loader FSM states: CNT_LO → CNT_HI → LOAD → (CHECK) → DONE; any state → ERR on framing error.
  - CNT_LO/CNT_HI: capture N. In CNT_HI, N > 2**ADDR_W → ERR; N = 0 → CHECK (or DONE without checksum).
  - LOAD: 2-bit byte index; byte k placed at bits [8k+7:8k]. On 4th byte: imem_we pulse, then imem_addr increments. After word N−1 written → CHECK/DONE.
  - DONE, ERR: terminal; only rst leaves them. Bytes received there are ignored.
- busy = 1 from first start bit of count_lo until DONE/ERR.
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, busy 0, done 0, err 0; FSM in CNT_LO, byte index 0, receiver idle.
- Reset mid-load: everything returns to reset values; next frame restarts at address 0; partially written memory contents are overwritten by the new image.

## Timing
- Received byte valid one cycle after stop-bit centre sample.
- imem_we asserted the cycle after the 4th byte valid, exactly one cycle wide; imem_addr/imem_wdata stable during it.
- Without checksum: done = 1 the cycle after the last imem_we; core_rst_n rises one cycle after done.
- With checksum: done one cycle after checksum byte valid (on match); core_rst_n one cycle later.
- err asserted the cycle after the failing byte/stop sample; core_rst_n stays 0.
- Back-to-back bytes (no idle between stop and next start) must be accepted.

## Configuration
- BOOT_CHECKSUM_EN defined: after data, one checksum byte expected, equal to XOR of all data bytes (count bytes excluded; N = 0 → 0x00). Match → DONE, mismatch → ERR.
- Undefined: no CHECK state, no checksum byte; DONE directly after last word.

## Structure
- Shared package boot_pkg: FSM state enum, frame constants (header length 2, bytes per word 4), DIV calculation function.
- One sub-module: uart_rx_byte (synchronizer, bit timer, glitch/framing check; outputs byte, byte_valid, frame_err).

## Test plan
- N=1, bytes 01 00 93 00 50 00 → one imem_we, addr 0, wdata 0x00500093; done=1, core_rst_n=1 one cycle later.
- N=0 (00 00) → no imem_we, done=1, err=0.
- N=2, second word's third byte with stop bit 0 → err=1, core_rst_n=0, only word 0 written.
- rx low pulse of DIV/4 cycles while idle → no byte, FSM remains CNT_LO, busy=0.
- ADDR_W=4, N=17 → err=1 after count_hi, no imem_we.
- rst low for one cycle during word 3 of N=5, then full N=2 image → writes at addr 0,1 only, done=1; with BOOT_CHECKSUM_EN, wrong checksum byte → err=1.
